// File: rtl/sdc_arb_pkg.sv
// rtl/sdc_arb_pkg.sv - shared types and helpers for the SD sector arbiter
package sdc_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_XFER   = 2'd2,
        S_FINISH = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int SECTOR_BYTES = 512;

    // Index width that stays at least one bit for a single-channel build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a pointer
module rr_arbiter
    import sdc_arb_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic                valid_o,
    output logic [CHANNELS-1:0] gnt_o,
    output logic [IDX_W-1:0]    idx_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan farthest-first so the candidate nearest the pointer overwrites last.
    always_comb begin
        valid_o  = 1'b0;
        gnt_o    = '0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                valid_o         = 1'b1;
                gnt_o           = '0;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sdc_sector_arbiter.sv
// rtl/sdc_sector_arbiter.sv - shares one SD sector engine between image client channels
module sdc_sector_arbiter
    import sdc_arb_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int SECTOR_W  = 32,
    parameter int ADDR_W    = 9,
    parameter int TIMEOUT_W = 20
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CHANNELS-1:0]          ch_rd,
    input  logic [CHANNELS-1:0]          ch_wr,
    input  logic [CHANNELS*SECTOR_W-1:0] ch_sector,
    input  logic [CHANNELS*8-1:0]        ch_wdata,
    output logic [CHANNELS-1:0]          ch_busy,
    output logic [CHANNELS-1:0]          ch_done,
    output logic [CHANNELS-1:0]          ch_error,
    output logic [CHANNELS-1:0]          ch_strobe,
    output logic [ADDR_W-1:0]            byte_addr,
    output logic [7:0]                   byte_data,
    output logic                         eng_rstart,
    output logic                         eng_wstart,
    output logic [SECTOR_W-1:0]          eng_sector,
    input  logic                         eng_busy,
    input  logic                         eng_done,
    input  logic                         eng_outen,
    input  logic [ADDR_W-1:0]            eng_outaddr,
    input  logic [7:0]                   eng_outbyte,
    input  logic [ADDR_W-1:0]            eng_inaddr,
    output logic [7:0]                   eng_inbyte
);

    localparam int               IDX_W   = idx_width(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(CHANNELS - 1);

    arb_state_t            state_q, state_d;
    logic [CHANNELS-1:0]   pending_q, pending_d;
    logic [CHANNELS-1:0]   op_wr_q, op_wr_d;
    logic [SECTOR_W-1:0]   sector_q [CHANNELS];
    logic [SECTOR_W-1:0]   sector_d [CHANNELS];
    logic [CHANNELS-1:0]   rd_prev_q, wr_prev_q;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
    logic [CHANNELS-1:0]   busy_q, busy_d;
    logic [CHANNELS-1:0]   error_q, error_d;

    logic [SECTOR_W-1:0]   sector_in [CHANNELS];
    logic [7:0]            wdata_in  [CHANNELS];
    logic [CHANNELS-1:0]   rd_rise, wr_rise;
    logic [CHANNELS-1:0]   pend_set, pend_clr, cap_err;
    logic [CHANNELS-1:0]   grant_oh;
    logic [CHANNELS-1:0]   arb_gnt;
    logic [IDX_W-1:0]      arb_idx, rr_next;
    logic                  arb_valid, tmo_fire, xfer;
    op_t                   grant_op;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign sector_in[g] = ch_sector[g*SECTOR_W +: SECTOR_W];
        assign wdata_in[g]  = ch_wdata[g*8 +: 8];
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_rr (
        .req_i   (pending_q),
        .ptr_i   (rr_q),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx)
    );

    assign rd_rise  = ch_rd & ~rd_prev_q;
    assign wr_rise  = ch_wr & ~wr_prev_q;
    assign grant_op = op_wr_q[grant_q] ? OP_WR : OP_RD;
    assign xfer     = (state_q == S_START) || (state_q == S_XFER);
    assign rr_next  = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    // An edge on a channel that is already queued or being served is refused.
    always_comb begin
        pend_set = '0;
        cap_err  = '0;
        op_wr_d  = op_wr_q;
        sector_d = sector_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_rise[i] || wr_rise[i]) begin
                if (pending_q[i] || (state_q != S_IDLE && grant_q == IDX_W'(i))) begin
                    cap_err[i] = 1'b1;
                end else begin
                    pend_set[i] = 1'b1;
                    op_wr_d[i]  = ~rd_rise[i];
                    sector_d[i] = sector_in[i];
                    cap_err[i]  = rd_rise[i] & wr_rise[i];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        tmo_d    = tmo_q;
        pend_clr = '0;
        tmo_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_idx;
                    pend_clr = arb_gnt;
                    tmo_d    = TIMEOUT_W'(1);
                    state_d  = S_START;
                end
            end
            S_START, S_XFER: begin
                tmo_d = tmo_q + 1'b1;
                if (eng_done) begin
                    state_d = S_FINISH;
                end else if (&tmo_q) begin
                    tmo_fire = 1'b1;
                    rr_d     = rr_next;
                    state_d  = S_IDLE;
                end else if (state_q == S_START && eng_busy) begin
                    state_d = S_XFER;
                end
            end
            S_FINISH: begin
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d = (pending_q | pend_set) & ~pend_clr;
        error_d   = cap_err | (tmo_fire ? grant_oh : '0);
        busy_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy_d[i] = pending_d[i] | ((state_d != S_IDLE) && (grant_d == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            op_wr_q   <= '0;
            sector_q  <= '{default: '0};
            rd_prev_q <= '0;
            wr_prev_q <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            tmo_q     <= '0;
            busy_q    <= '0;
            error_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            op_wr_q   <= op_wr_d;
            sector_q  <= sector_d;
            rd_prev_q <= ch_rd;
            wr_prev_q <= ch_wr;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    assign ch_busy    = busy_q;
    assign ch_error   = error_q;
    assign ch_done    = (state_q == S_FINISH) ? grant_oh : '0;
    assign ch_strobe  = (xfer && eng_outen) ? grant_oh : '0;
    assign byte_addr  = !xfer ? '0 : ((grant_op == OP_RD) ? eng_outaddr : eng_inaddr);
    assign byte_data  = xfer ? eng_outbyte : 8'd0;
    assign eng_rstart = (state_q == S_START) && (grant_op == OP_RD);
    assign eng_wstart = (state_q == S_START) && (grant_op == OP_WR);
    assign eng_sector = (state_q != S_IDLE) ? sector_q[grant_q] : '0;
    assign eng_inbyte = (xfer && grant_op == OP_WR) ? wdata_in[grant_q] : 8'd0;

endmodule

// File: doc/sdc_sector_arbiter.md
Name: sdc_sector_arbiter

Overview:
- Shares one SD sector engine (sd_rw-style: rstart/wstart, rbusy/rdone, outen/outaddr/outbyte, inbyte) between CHANNELS floppy/HDD image clients, each issuing sector reads and writes.
- Successor to the fixed 4-bit read-only sdc_rd bundle: it adds a parametrised channel count, write mode, round-robin fairness, per-channel result routing and a timeout.
- Sits between the nanomig core's drive controllers and the SD card controller. The same instance serves synthesis and the SD_EMU simulation.

Parameters:
CHANNELS, 4, number of client channels (1..8)
SECTOR_W, 32, sector number width
ADDR_W, 9, byte index width within a 512-byte sector
TIMEOUT_W, 20, timeout counter width; timeout fires at 2^TIMEOUT_W-1 clk cycles

Ports:
clk  in  1  system clock (28.375 MHz)
rstn  in  1  synchronous, active-low reset
ch_rd  in  CHANNELS  per-channel read request, level, rising edge sampled
ch_wr  in  CHANNELS  per-channel write request, level, rising edge sampled
ch_sector  in  CHANNELS*SECTOR_W  per-channel sector number, channel i at [i*SECTOR_W +: SECTOR_W]
ch_wdata  in  CHANNELS*8  per-channel write byte for the current byte address
ch_busy  out  CHANNELS  request pending or in service
ch_done  out  CHANNELS  one-cycle pulse on successful completion
ch_error  out  CHANNELS  one-cycle pulse on timeout or rejected request
ch_strobe  out  CHANNELS  read-byte strobe, granted channel only
byte_addr  out  ADDR_W  shared byte address (read data or write fetch)
byte_data  out  8  shared read byte
eng_rstart  out  1  engine read start
eng_wstart  out  1  engine write start
eng_sector  out  SECTOR_W  engine sector number
eng_busy  in  1  engine busy
eng_done  in  1  engine completion pulse
eng_outen  in  1  engine read-byte valid
eng_outaddr  in  ADDR_W  engine read-byte address
eng_outbyte  in  8  engine read byte
eng_inaddr  in  ADDR_W  engine write-byte fetch address
eng_inbyte  out  8  write byte to engine

Behaviour:
- Reset (rstn=0 at a clk edge): all outputs 0; pending, op and edge registers cleared; rr pointer=0; FSM=IDLE. An engine transaction in flight is abandoned, with no done or error pulses.
- Request capture:
  - A rising edge of ch_rd[i] or ch_wr[i] sets pending[i] and latches op[i] (read/write) and ch_sector[i] into a per-channel register.
  - If both rise in the same cycle: read is captured, and ch_error[i] pulses for the dropped write.
  - An edge while pending[i] or in service is ignored and pulses ch_error[i].
- ch_busy[i] = pending[i] | (granted==i and FSM!=IDLE). It is registered, rising the cycle after the edge.
- FSM states: IDLE, START, XFER, FINISH.
  - IDLE: if any pending bit is set, grant the first pending channel at or after rr_ptr (wrapping mod CHANNELS) and clear its pending bit. Go to START next cycle.
  - START: drive eng_sector=latched sector, and eng_rstart or eng_wstart=1. Hold until eng_busy=1, then drop start and go to XFER.
  - XFER: wait for eng_done=1, then go to FINISH. An eng_done arriving during START is treated identically, covering engines whose busy is shorter than one cycle.
  - FINISH: ch_done[grant] pulses for one cycle; rr_ptr=(grant+1) mod CHANNELS; ch_busy[grant] clears; go to IDLE.
- Minimum request-to-start latency: 2 cycles (edge, capture, grant, START).
- Timeout:
  - The counter resets on entry to START and counts in START and XFER.
  - At terminal count: start drops, ch_error[grant] pulses (no ch_done), rr_ptr advances, FSM goes to IDLE.
  - A late eng_done after a timeout is ignored.
- Read routing is combinational pass-through with no added latency:
  - ch_strobe[grant]=eng_outen in XFER/START only.
  - byte_addr=eng_outaddr when op is read, else eng_inaddr.
  - byte_data=eng_outbyte.
- Write routing: eng_inbyte = ch_wdata[grant] (combinational), and the client must present data for byte_addr in the same cycle. eng_inbyte=0 when not writing.
- Arithmetic: rr_ptr and grant are $clog2(CHANNELS) bits wide and wrap explicitly at CHANNELS (non-power-of-two safe).

Decomposition:
- Package sdc_arb_pkg: FSM state enum, op_t (OP_RD, OP_WR), SECTOR_BYTES=512 constant, and a clog2-based index width helper.
- Sub-module rr_arbiter: inputs req vector and pointer, outputs one-hot grant and index; purely combinational, parametrised by CHANNELS.

Test Plan:
- Single read: ch_rd[1] rises with sector 0x0000_0040; engine busy after 3 cycles, 512 outen bytes, done → eng_sector=0x40, eng_rstart high until busy, ch_strobe[1] only, ch_done[1] single pulse, ch_busy[1] low the next cycle.
- Fairness: ch_rd[0], ch_rd[2] and ch_wr[3] all rise in the same cycle with rr_ptr=0 → service order 0, 2, 3; the next simultaneous request set {0,3} is served 0, then 3.
- Write: ch_wr[2] with sector 7, ch_wdata[2]=byte_addr[7:0] → eng_wstart asserted, eng_inbyte equals eng_inaddr[7:0] for all 512 fetches, ch_done[2] pulses.
- Timeout (TIMEOUT_W=4): engine never raises busy → after 15 cycles in START, ch_error[0] pulses, no ch_done, FSM returns to IDLE; the queued ch_rd[1] is then serviced.
- Conflicts: ch_rd[3] and ch_wr[3] rise together → read executed, ch_error[3] pulses once. A re-edge of ch_rd[3] during service gives another error pulse and no second transaction.
- Reset mid-XFER: rstn=0 for 1 cycle after 100 bytes → all outputs 0 the next cycle, no done/error pulses, rr_ptr=0, and a new request completes normally.
